// File: rtl/tile_stream_gather.sv
// Gathers NUM_TILES incoming tiles (or fewer, when closed early by in_last)
// into one wide vector and holds it until the downstream consumes it.
module tile_stream_gather #(
  parameter  int TILE_SIZE  = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_TILES  = 4,
  localparam int CNT_W      = $clog2(NUM_TILES + 1),
  localparam int VEC_LEN    = NUM_TILES * TILE_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_vec [TILE_SIZE],
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_vec [VEC_LEN],
  output logic [CNT_W-1:0]             out_tiles,
  output logic                         out_last
);

  typedef enum logic {COLLECT, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_TILES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tile_cnt;
  logic [CNT_W-1:0] wr_slot;
  logic             in_fire, out_fire, close;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // A tile accepted while a vector is held can only arrive together with the
  // output fire, so it always starts the next vector at slot 0.
  assign wr_slot  = (state == HOLD) ? '0 : tile_cnt;
  assign close    = in_fire && ((wr_slot == LAST_SLOT) || in_last);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // NOTE: combinational outputs get a default before any branch so no path
  // leaves them unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (close) state_nxt = HOLD;
      HOLD:    if (out_fire) state_nxt = close ? HOLD : COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (state == HOLD) begin
      in_ready  = out_ready;
      out_valid = 1'b1;
    end
  end

  // NOTE: the slot storage is reset, because unwritten slots and the reset
  // output must read as zero rather than stale or unknown data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_cnt  <= '0;
      out_tiles <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < VEC_LEN; i++) out_vec[i] <= '0;
    end else begin
      if (out_fire)     tile_cnt <= in_fire ? CNT_W'(1) : '0;
      else if (in_fire) tile_cnt <= tile_cnt + CNT_W'(1);

      if (close) begin
        out_tiles <= wr_slot + CNT_W'(1);
        out_last  <= in_last;
      end else if (out_fire) begin
        out_tiles <= '0;
        out_last  <= 1'b0;
      end

      // A slot written in the consuming cycle survives the clear.
      for (int k = 0; k < NUM_TILES; k++) begin
        for (int e = 0; e < TILE_SIZE; e++) begin
          if (in_fire && (wr_slot == CNT_W'(k)))
            out_vec[k*TILE_SIZE + e] <= in_vec[e];
          else if (out_fire)
            out_vec[k*TILE_SIZE + e] <= '0;
        end
      end
    end
  end

endmodule

// File: doc/tile_stream_gather.md
TILE_STREAM_GATHER -- requirements
Module: tile_stream_gather

Interface
REQ-001 Parameter TILE_SIZE, default 4, elements per incoming tile.
REQ-002 Parameter DATA_WIDTH, default 16, signed element width.
REQ-003 Parameter NUM_TILES, default 4, tiles per gathered vector; legal range 2..64.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream tile valid.
REQ-007 in_ready  output  1  block can accept a tile this cycle.
REQ-008 in_vec  input  signed DATA_WIDTH x TILE_SIZE (unpacked array)  incoming tile.
REQ-009 in_last  input  1  marks the final tile of a group, sampled with in_vec.
REQ-010 out_valid  output  1  gathered vector valid.
REQ-011 out_ready  input  1  downstream accepts the gathered vector.
REQ-012 out_vec  output  signed DATA_WIDTH x (NUM_TILES*TILE_SIZE) (unpacked array)  gathered vector; tile k occupies elements [k*TILE_SIZE +: TILE_SIZE].
REQ-013 out_tiles  output  $clog2(NUM_TILES+1)  number of valid tiles in out_vec (1..NUM_TILES).
REQ-014 out_last  output  1  vector was closed by in_last.

Function
REQ-015 The block SHALL implement two states: COLLECT (filling) and HOLD (presenting a vector).
REQ-016 Input fire = in_valid && in_ready; output fire = out_valid && out_ready.
REQ-017 In COLLECT, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 On input fire in COLLECT, in_vec SHALL be written into slot tile_cnt and tile_cnt incremented.
REQ-019 If the written slot is NUM_TILES-1 or in_last=1, the next state SHALL be HOLD, with out_tiles = slot+1 and out_last = in_last, both registered.
REQ-020 In HOLD, out_valid SHALL be 1, and out_vec, out_tiles and out_last SHALL remain constant until output fire.
REQ-021 In HOLD, in_ready SHALL equal out_ready, so a tile can be accepted in the same cycle the held vector is consumed (no bubble).
REQ-022 On output fire, tile_cnt SHALL restart at 0.
  - If an input fire occurs in the same cycle, that tile SHALL go to slot 0 and tile_cnt SHALL become 1.
  - The state SHALL return to COLLECT, unless that simultaneous tile itself closes a vector (NUM_TILES=1 not legal, so only via in_last), in which case the state SHALL stay HOLD with new contents.
REQ-023 Slots not written in the current vector SHALL read as zero.
  - All slots SHALL clear on output fire, except a slot written in that same cycle.
REQ-024 Latency: out_valid SHALL rise in the cycle after the closing input fire.
REQ-025 No tile SHALL ever be dropped or duplicated; in_ready=0 SHALL be the only backpressure mechanism.
REQ-026 in_valid=1 with in_ready=0 SHALL leave all state unchanged.
REQ-027 Element values SHALL pass through bit-exact (no arithmetic, no sign change).

Reset
REQ-028 While rst_n=0, the block SHALL enter COLLECT and clear tile_cnt to 0.
  - Outputs: out_valid=0, out_vec all 0, out_tiles=0, out_last=0.
  - in_ready SHALL be 1 once rst_n is released.
REQ-029 Reset asserted mid-vector or in HOLD SHALL discard all partial or held data, with no output after release until a new closing tile is received.

Verification
REQ-030 Full group: 4 tiles {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, in_last=0, out_ready=1 -> one vector with elements 1..16 in order, out_tiles=4, out_last=0, out_valid one cycle after the 4th fire.
REQ-031 Early last: 2 tiles, the second with in_last=1 -> out_tiles=2, out_last=1, elements 8..15 = 0.
REQ-032 Backpressure: out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0, out_vec stable for 5 cycles, no tile lost; the next vector is correct after release.
REQ-033 Back-to-back: in_valid=1 continuously, out_ready=1 -> 8 tiles produce 2 vectors with zero idle input cycles; the tile accepted on the output-fire cycle lands in slot 0.
REQ-034 Reset mid-operation: rst_n pulsed low after 2 tiles -> out_valid=0, out_vec=0; the next 4 tiles form a clean vector with no stale data.
REQ-035 Random valid/ready toggling, 1000 tiles with random in_last -> scoreboard matches the reference gathering model; out_vec never changes while out_valid=1 and out_ready=0.
